// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-port memory arbiter
package mem_arb_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 12;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rtl/mem_arbiter_rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic win_o,
  output logic valid_o
);

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    valid_o = req0_i | req1_i;
    if (req0_i && req1_i) begin
      win_o = ~last_i;
    end else if (req1_i) begin
      win_o = PORT_DATA;
    end else begin
      win_o = PORT_FETCH;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter/sequencer for the shared single-port memory
// Optional per-port completion counters with MEM_ARB_STATS_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_rden,
  output logic          mem_wren,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_cnt0,
  output logic [15:0]   stat_cnt1
`endif
);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic          mem_rden_q, mem_rden_d, mem_wren_q, mem_wren_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic pick_win, pick_valid;

  rr_pick2 u_pick (
    .req0_i  (req0),
    .req1_i  (req1),
    .last_i  (last_q),
    .win_o   (pick_win),
    .valid_o (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= PORT_DATA;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      mem_rden_q  <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      mem_rden_q  <= mem_rden_d;
      mem_wren_q  <= mem_wren_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // last_q doubles as the owner of the access in flight.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    mem_rden_d  = 1'b0;
    mem_wren_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;

    case (state_q)
      IDLE, DONE: begin
        if (pick_valid) begin
          state_d = ACCESS;
          last_d  = pick_win;
          if (pick_win == PORT_DATA) begin
            gnt1_d      = 1'b1;
            mem_addr_d  = addr1;
            mem_wdata_d = wdata1;
            mem_wren_d  = we1;
            mem_rden_d  = ~we1;
          end else begin
            gnt0_d      = 1'b1;
            mem_addr_d  = addr0;
            mem_wdata_d = wdata0;
            mem_wren_d  = we0;
            mem_rden_d  = ~we0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (last_q == PORT_DATA) begin
          done1_d = 1'b1;
          if (mem_rden_q) rdata1_d = mem_rdata;
        end else begin
          done0_d = 1'b1;
          if (mem_rden_q) rdata0_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_rden  = mem_rden_q;
  assign mem_wren  = mem_wren_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_cnt0_q, stat_cnt0_d, stat_cnt1_q, stat_cnt1_d;

  // Counters advance on the edge that closes the done cycle and saturate.
  always_comb begin
    stat_cnt0_d = stat_cnt0_q;
    stat_cnt1_d = stat_cnt1_q;
    if (done0_q && (stat_cnt0_q != 16'hFFFF)) stat_cnt0_d = stat_cnt0_q + 16'd1;
    if (done1_q && (stat_cnt1_q != 16'hFFFF)) stat_cnt1_d = stat_cnt1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_cnt0_q <= '0;
      stat_cnt1_q <= '0;
    end else begin
      stat_cnt0_q <= stat_cnt0_d;
      stat_cnt1_q <= stat_cnt1_d;
    end
  end

  assign stat_cnt0 = stat_cnt0_q;
  assign stat_cnt1 = stat_cnt1_q;
`endif

endmodule
